wavelet_envelope_scanner: RTL and testbench
===========================================

// Module: wavelet_envelope_scanner
// PURPOSE
//   Downstream stage of the wavelet FIR bank. Captures all NUM_FILTERS filter
//   outputs on each sample strobe and runs one peak-hold/decay envelope per band.
//   Envelope updates use a single time-shared abs/decay datapath.
//   Emits per-band envelopes as a valid/ready stream and drives a threshold LED.
// PARAMETERS
//   NUM_FILTERS  8      number of FIR bands (>=2); index width IDX_W = $clog2(NUM_FILTERS)
//   OUT_BITS     16     width of each signed FIR output; ENV_BITS = OUT_BITS-1
//   DECAY_SHIFT  4      envelope decay per sample = env >> DECAY_SHIFT (min 1 if env!=0)
//   THRESHOLD    1024   o_LED asserts when any envelope >= THRESHOLD (unsigned, ENV_BITS)
// PORTS
//   clk            in   1                      system clock, rising edge
//   reset          in   1                      synchronous, active-high
//   i_filter_out   in   NUM_FILTERS*OUT_BITS   packed signed outputs, band k at [k*OUT_BITS +: OUT_BITS]
//   i_sample_strobe in  1                      1-cycle pulse: i_filter_out valid for a new sample
//   o_valid        out  1                      envelope word valid
//   i_ready        in   1                      consumer accepts when o_valid & i_ready
//   o_index        out  IDX_W                  band index of o_env
//   o_env          out  ENV_BITS               unsigned envelope of band o_index
//   o_frame_done   out  1                      1-cycle pulse after last band accepted
//   o_overrun      out  1                      sticky: strobe arrived while not IDLE
//   o_busy         out  1                      high in UPDATE or EMIT
//   o_LED          out  1                      registered threshold indicator
// BEHAVIOUR
//   Reset: state=IDLE; all envelopes, snapshot, o_index, o_env = 0;
//     o_valid, o_frame_done, o_overrun, o_busy, o_LED = 0. Reset mid-UPDATE or
//     mid-EMIT aborts immediately, with no frame_done pulse.
//   FSM: IDLE -> UPDATE -> EMIT -> IDLE.
//   IDLE: on i_sample_strobe, register i_filter_out into the snapshot, set k=0,
//     and go to UPDATE on the same edge.
//   UPDATE: one band per cycle, k = 0..NUM_FILTERS-1.
//     a   = |snap[k]|; if snap[k] == -2^(OUT_BITS-1), saturate to 2^(OUT_BITS-1)-1.
//     d   = env[k]>>DECAY_SHIFT; if d==0 and env[k]!=0, then d=1.
//     dec = env[k] - d (never underflows).
//     env[k] <= (a > dec) ? a : dec.
//     On the cycle with k = NUM_FILTERS-1: o_LED <= OR over all bands of
//     (new env >= THRESHOLD), using the updated values; k<=0; go to EMIT.
//   EMIT: o_valid=1, o_index=k, o_env=env[k]; these hold stable while !i_ready.
//     On valid&ready: k++. If k was NUM_FILTERS-1: o_valid<=0, o_frame_done<=1
//     for one cycle, go to IDLE.
//   Latency: strobe at edge t -> first o_valid visible after edge t+NUM_FILTERS+1
//     (8 UPDATE cycles + 1). With i_ready tied high, a frame is done in
//     2*NUM_FILTERS+1 cycles.
//   Strobe while busy is dropped: snapshot and envelopes are unchanged, o_overrun<=1.
//     o_overrun clears only on reset. A strobe on the same cycle as the final
//     accept is also dropped, because the FSM is not yet IDLE.
//   o_busy = (state != IDLE). All outputs are registered except o_busy, which
//     decodes state.
// TESTING
//   1) Reset, all inputs 0, strobe -> 8 words, index 0..7, env=0; frame_done after word 7; o_LED=0.
//   2) Band 3 = -2000, others 0, strobe, ready=1 -> env[3]=2000, o_LED=1; next strobe with band 3=0
//      -> env[3]=1875 (2000-125).
//   3) Band 0 = -32768 -> env[0]=32767; band 1 = 32767 -> env[1]=32767.
//   4) Decay floor: env=5, input 0 -> 4,3,2,1,0,0 over successive strobes (min step 1).
//   5) i_ready low for 10 cycles on word 2 -> o_index=2 and o_env held stable; a strobe during
//      EMIT sets o_overrun=1; envelopes are unchanged.
//   6) Assert reset during UPDATE at k=4 -> next cycle: IDLE, all env 0, o_valid=0, no frame_done.

Source files
------------

// File: rtl/wavelet_envelope_scanner.sv
// Per-band peak-hold/decay envelope scanner behind the wavelet FIR bank.
// One shared abs/decay datapath walks the bands, then streams the envelopes out.
module wavelet_envelope_scanner #(
  parameter  int NUM_FILTERS = 8,
  parameter  int OUT_BITS    = 16,
  parameter  int DECAY_SHIFT = 4,
  parameter  int THRESHOLD   = 1024,
  localparam int IDX_W       = $clog2(NUM_FILTERS),
  localparam int ENV_BITS    = OUT_BITS - 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_FILTERS*OUT_BITS-1:0] i_filter_out,
  input  logic                            i_sample_strobe,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [IDX_W-1:0]                o_index,
  output logic [ENV_BITS-1:0]             o_env,
  output logic                            o_frame_done,
  output logic                            o_overrun,
  output logic                            o_busy,
  output logic                            o_LED
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_EMIT
  } state_t;

  localparam logic [IDX_W-1:0]    LAST    = IDX_W'(NUM_FILTERS - 1);
  localparam logic [ENV_BITS-1:0] ENV_MAX = {ENV_BITS{1'b1}};
  localparam logic [ENV_BITS-1:0] THR     = ENV_BITS'(THRESHOLD);

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0]           r_k;
  logic signed [OUT_BITS-1:0] r_snap [NUM_FILTERS];
  logic [ENV_BITS-1:0]        r_env  [NUM_FILTERS];

  logic                r_valid;
  logic [IDX_W-1:0]    r_index;
  logic [ENV_BITS-1:0] r_env_o;
  logic                r_fdone;
  logic                r_ovr;
  logic                r_led;

  logic signed [OUT_BITS-1:0] w_s;
  logic [OUT_BITS-1:0]        w_mag;
  logic [ENV_BITS-1:0]        w_abs;
  logic [ENV_BITS-1:0]        w_cur;
  logic [ENV_BITS-1:0]        w_d;
  logic [ENV_BITS-1:0]        w_dec;
  logic [ENV_BITS-1:0]        w_new;
  logic                       w_led;

  assign w_s = r_snap[r_k];

  // Shared abs/decay datapath for band r_k
  always_comb begin
    w_cur = r_env[r_k];
    w_mag = w_s[OUT_BITS-1] ? -w_s : w_s;
    if (w_mag[OUT_BITS-1]) begin
      w_abs = ENV_MAX;
    end else begin
      w_abs = w_mag[ENV_BITS-1:0];
    end
    w_d = w_cur >> DECAY_SHIFT;
    if (w_d == '0 && w_cur != '0) begin
      w_d = ENV_BITS'(1);
    end
    w_dec = w_cur - w_d;
    w_new = (w_abs > w_dec) ? w_abs : w_dec;
  end

  // Threshold over all bands, substituting the value being written now
  always_comb begin
    w_led = 1'b0;
    for (int j = 0; j < NUM_FILTERS; j++) begin
      if (IDX_W'(j) == r_k) begin
        w_led = w_led | (w_new >= THR);
      end else begin
        w_led = w_led | (r_env[j] >= THR);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_sample_strobe) begin
          w_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (r_k == LAST) begin
          w_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (r_valid && i_ready && r_k == LAST) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k     <= '0;
      r_valid <= 1'b0;
      r_index <= '0;
      r_env_o <= '0;
      r_fdone <= 1'b0;
      r_ovr   <= 1'b0;
      r_led   <= 1'b0;
      for (int k = 0; k < NUM_FILTERS; k++) begin
        r_snap[k] <= '0;
        r_env[k]  <= '0;
      end
    end else begin
      r_fdone <= 1'b0;
      if (i_sample_strobe && r_state != S_IDLE) begin
        r_ovr <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_sample_strobe) begin
            for (int k = 0; k < NUM_FILTERS; k++) begin
              r_snap[k] <= i_filter_out[k*OUT_BITS +: OUT_BITS];
            end
            r_k <= '0;
          end
        end
        S_UPDATE: begin
          r_env[r_k] <= w_new;
          if (r_k == LAST) begin
            r_led <= w_led;
            r_k   <= '0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_EMIT: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_index <= r_k;
            r_env_o <= r_env[r_k];
          end else if (i_ready) begin
            if (r_k == LAST) begin
              r_valid <= 1'b0;
              r_fdone <= 1'b1;
              r_k     <= '0;
            end else begin
              r_k     <= r_k + 1'b1;
              r_index <= r_k + 1'b1;
              r_env_o <= r_env[r_k+1'b1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid      = r_valid;
  assign o_index      = r_index;
  assign o_env        = r_env_o;
  assign o_frame_done = r_fdone;
  assign o_overrun    = r_ovr;
  assign o_LED        = r_led;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_wavelet_envelope_scanner.sv
// Directed bench for wavelet_envelope_scanner.
// Hand-computed envelopes checked word by word on the output stream.
module tb_wavelet_envelope_scanner;

  localparam int N  = 8;
  localparam int OB = 16;
  localparam int EB = 15;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*OB-1:0] i_filter_out;
  logic            i_sample_strobe;
  logic            o_valid;
  logic            i_ready;
  logic [IW-1:0]   o_index;
  logic [EB-1:0]   o_env;
  logic            o_frame_done;
  logic            o_overrun;
  logic            o_busy;
  logic            o_LED;

  wavelet_envelope_scanner #(
    .NUM_FILTERS(N),
    .OUT_BITS(OB),
    .DECAY_SHIFT(4),
    .THRESHOLD(1024)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_filter_out(i_filter_out),
    .i_sample_strobe(i_sample_strobe),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_index(o_index),
    .o_env(o_env),
    .o_frame_done(o_frame_done),
    .o_overrun(o_overrun),
    .o_busy(o_busy),
    .o_LED(o_LED)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic signed [OB-1:0] bands   [N];
  logic [EB-1:0]        exp_env [N];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bands();
    for (int k = 0; k < N; k++) begin
      i_filter_out[k*OB +: OB] = bands[k];
    end
  endtask

  task automatic clear_bands();
    for (int k = 0; k < N; k++) begin
      bands[k]   = '0;
      exp_env[k] = '0;
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    i_sample_strobe = 1'b0;
    i_ready         = 1'b0;
    i_filter_out    = '0;
    tick();
    tick();
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_index", 32'(o_index), 0);
    chk("rst_env", 32'(o_env), 0);
    chk("rst_fdone", 32'(o_frame_done), 0);
    chk("rst_ovr", 32'(o_overrun), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_led", 32'(o_LED), 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic run_frame(input string nm, input logic exp_led);
    int cyc;
    drive_bands();
    i_ready         = 1'b1;
    i_sample_strobe = 1'b1;
    tick();
    i_sample_strobe = 1'b0;
    chk({nm, "_busy"}, 32'(o_busy), 1);
    cyc = 0;
    while (!o_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    chk({nm, "_latency"}, 32'(cyc), 9);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_idx%0d", nm, i), 32'(o_index), 32'(i));
      chk($sformatf("%s_env%0d", nm, i), 32'(o_env), 32'(exp_env[i]));
      chk($sformatf("%s_fd%0d", nm, i), 32'(o_frame_done), 0);
      tick();
    end
    chk({nm, "_fdone"}, 32'(o_frame_done), 1);
    chk({nm, "_vend"}, 32'(o_valid), 0);
    chk({nm, "_led"}, 32'(o_LED), 32'(exp_led));
    tick();
    chk({nm, "_fdone_pulse"}, 32'(o_frame_done), 0);
    chk({nm, "_idle"}, 32'(o_busy), 0);
  endtask

  initial begin
    clear_bands();
    do_reset();

    // 1) zero frame
    run_frame("t1", 1'b0);

    // 2) band 3 = -2000, then decay by 125
    clear_bands();
    bands[3]   = -16'sd2000;
    exp_env[3] = 15'd2000;
    run_frame("t2a", 1'b1);
    bands[3]   = '0;
    exp_env[3] = 15'd1875;
    run_frame("t2b", 1'b1);

    // 3) saturation of most-negative input, positive full scale
    bands[0]   = 16'sh8000;
    bands[1]   = 16'sh7fff;
    exp_env[0] = 15'd32767;
    exp_env[1] = 15'd32767;
    exp_env[3] = 15'd1758;
    run_frame("t3", 1'b1);

    // 4) decay floor of one per sample
    do_reset();
    clear_bands();
    bands[2]   = 16'sd5;
    exp_env[2] = 15'd5;
    run_frame("t4_5", 1'b0);
    bands[2]   = '0;
    exp_env[2] = 15'd4;
    run_frame("t4_4", 1'b0);
    exp_env[2] = 15'd3;
    run_frame("t4_3", 1'b0);
    exp_env[2] = 15'd2;
    run_frame("t4_2", 1'b0);
    exp_env[2] = 15'd1;
    run_frame("t4_1", 1'b0);
    exp_env[2] = 15'd0;
    run_frame("t4_0a", 1'b0);
    run_frame("t4_0b", 1'b0);

    // 5) backpressure on word 2 and a dropped strobe
    clear_bands();
    bands[2] = 16'sd300;
    drive_bands();
    i_ready         = 1'b0;
    i_sample_strobe = 1'b1;
    tick();
    i_sample_strobe = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (!o_valid && cyc < 30) begin
        tick();
        cyc++;
      end
      chk("t5_latency", 32'(cyc), 9);
    end
    chk("t5_idx0", 32'(o_index), 0);
    i_ready = 1'b1;
    tick();
    tick();
    i_ready  = 1'b0;
    bands[2] = 16'sd5000;
    drive_bands();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("t5_hold_idx%0d", c), 32'(o_index), 2);
      chk($sformatf("t5_hold_env%0d", c), 32'(o_env), 300);
      chk($sformatf("t5_hold_v%0d", c), 32'(o_valid), 1);
      i_sample_strobe = (c == 3);
      tick();
    end
    i_sample_strobe = 1'b0;
    chk("t5_overrun", 32'(o_overrun), 1);
    i_ready = 1'b1;
    for (int i = 2; i < N; i++) begin
      chk($sformatf("t5_idx%0d", i), 32'(o_index), 32'(i));
      chk($sformatf("t5_env%0d", i), 32'(o_env), (i == 2) ? 300 : 0);
      tick();
    end
    chk("t5_fdone", 32'(o_frame_done), 1);
    chk("t5_led", 32'(o_LED), 0);
    tick();
    clear_bands();
    exp_env[2] = 15'd282;
    run_frame("t5_after", 1'b0);
    chk("t5_ovr_sticky", 32'(o_overrun), 1);

    // 6) reset in the middle of UPDATE
    for (int k = 0; k < N; k++) begin
      bands[k] = 16'sd2000;
    end
    drive_bands();
    i_sample_strobe = 1'b1;
    tick();
    i_sample_strobe = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("t6_busy_pre", 32'(o_busy), 1);
    reset = 1'b1;
    tick();
    chk("t6_busy", 32'(o_busy), 0);
    chk("t6_valid", 32'(o_valid), 0);
    chk("t6_fdone", 32'(o_frame_done), 0);
    chk("t6_ovr", 32'(o_overrun), 0);
    chk("t6_led", 32'(o_LED), 0);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("t6_quiet_fd%0d", c), 32'(o_frame_done), 0);
      chk($sformatf("t6_quiet_v%0d", c), 32'(o_valid), 0);
    end
    clear_bands();
    run_frame("t6_after", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
